// File: rtl/jam_pkg.sv
// Shared types and width helpers for the job-assignment solver.
// The solver reads an N x N cost table and searches every assignment for the best total.
package jam_pkg;

  typedef enum logic [1:0] {IDLE, LOAD, EVAL, DONE} state_t;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (r = 0; (1 << r) < v; r++) begin
    end
    return r;
  endfunction

  // Address width; a single worker still needs one address bit.
  function automatic int idxWidth(input int n);
    return (clog2(n) < 1) ? 1 : clog2(n);
  endfunction

  // Width of a total cost, which is the sum of n elements that are cw bits wide.
  function automatic int totalWidth(input int cw, input int n);
    return cw + clog2(n);
  endfunction

endpackage

// File: rtl/jam_gen_if.sv
// Handshake, cost-ROM and result bundle for jam_gen.
// slave is the solver side; master is the requester/ROM side.
interface jam_gen_if #(
  parameter int N   = 8,
  parameter int CW  = 7,
  parameter int MCW = 16
);
  import jam_pkg::*;

  localparam int IW = idxWidth(N);
  localparam int TW = totalWidth(CW, N);

  logic              i_start;
  logic              i_mode;
  logic [IW-1:0]     o_w;
  logic [IW-1:0]     o_j;
  logic [CW-1:0]     i_cost;
  logic              o_busy;
  logic              o_valid;
  logic [MCW-1:0]    o_matchCount;
  logic [TW-1:0]     o_minCost;
  logic [N*IW-1:0]   o_bestPerm;

  modport slave (
    input  i_start, i_mode, i_cost,
    output o_w, o_j, o_busy, o_valid, o_matchCount, o_minCost, o_bestPerm
  );

  modport master (
    output i_start, i_mode, i_cost,
    input  o_w, o_j, o_busy, o_valid, o_matchCount, o_minCost, o_bestPerm
  );

endinterface

// File: rtl/jam_nextperm.sv
// Combinational lexicographic successor of a permutation.
// o_last flags the final permutation, which is the one that has no pivot.
module jam_nextperm #(
  parameter int N  = 8,
  parameter int IW = 3
) (
  input  logic [N*IW-1:0] i_perm,
  output logic [N*IW-1:0] o_next,
  output logic            o_last
);

  logic [IW-1:0] w_p [N];
  logic [IW-1:0] w_s [N];
  int            w_pivot;
  int            w_swap;
  logic          w_found;

  always_comb begin
    for (int k = 0; k < N; k++) begin
      w_p[k] = i_perm[k*IW +: IW];
    end

    w_found = 1'b0;
    w_pivot = 0;
    for (int i = 0; i < N - 1; i++) begin
      if (w_p[i] < w_p[i+1]) begin
        w_found = 1'b1;
        w_pivot = i;
      end
    end

    w_swap = w_pivot;
    for (int k = 0; k < N; k++) begin
      if ((k > w_pivot) && (w_p[k] > w_p[w_pivot])) begin
        w_swap = k;
      end
    end

    for (int k = 0; k < N; k++) begin
      w_s[k] = w_p[k];
    end
    w_s[w_pivot] = w_p[w_swap];
    w_s[w_swap]  = w_p[w_pivot];

    // The suffix after the pivot is descending after the swap, so mirroring it gives ascending order.
    o_next = '0;
    for (int k = 0; k < N; k++) begin
      if (k > w_pivot) begin
        o_next[k*IW +: IW] = w_s[N + w_pivot - k];
      end else begin
        o_next[k*IW +: IW] = w_s[k];
      end
    end

    o_last = ~w_found;
  end

endmodule

// File: rtl/jam_gen.sv
// Parametrised job-assignment solver. It loads an N x N cost table from a ROM
// and then scores one permutation per cycle, tracking the best total and how often it occurs.
module jam_gen
  import jam_pkg::*;
#(
  parameter int N   = 8,
  parameter int CW  = 7,
  parameter int MCW = 16
) (
  input  logic       i_clk,
  input  logic       i_rst,
  jam_gen_if.slave   bus
);

  localparam int IW = idxWidth(N);
  localparam int TW = totalWidth(CW, N);
  localparam int PW = N * IW;
  localparam logic [MCW-1:0] COUNT_MAX = '1;
  localparam logic [IW-1:0]  LAST_IDX  = IW'(N - 1);

  state_t         r_state;
  logic           r_mode;
  logic           r_first;
  logic           r_busy;
  logic           r_valid;
  logic [IW-1:0]  r_w;
  logic [IW-1:0]  r_j;
  logic [CW-1:0]  r_table [N][N];
  logic [PW-1:0]  r_perm;
  logic [PW-1:0]  r_bestPerm;
  logic [PW-1:0]  r_bestPermOut;
  logic [TW-1:0]  r_best;
  logic [TW-1:0]  r_minCost;
  logic [MCW-1:0] r_count;
  logic [MCW-1:0] r_matchCount;

  logic [PW-1:0]  w_nextPerm;
  logic           w_last;
  logic [TW-1:0]  w_total;
  logic           w_better;
  logic           w_equal;

  function automatic logic [PW-1:0] identityPerm();
    logic [PW-1:0] p;
    p = '0;
    for (int w = 0; w < N; w++) begin
      p[w*IW +: IW] = IW'(w);
    end
    return p;
  endfunction

  jam_nextperm #(.N(N), .IW(IW)) u_nextperm (
    .i_perm (r_perm),
    .o_next (w_nextPerm),
    .o_last (w_last)
  );

  always_comb begin
    w_total = '0;
    for (int w = 0; w < N; w++) begin
      w_total = w_total + TW'(r_table[w][r_perm[w*IW +: IW]]);
    end
  end

  assign w_better = r_mode ? (w_total > r_best) : (w_total < r_best);
  assign w_equal  = (w_total == r_best);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state       <= IDLE;
      r_mode        <= 1'b0;
      r_first       <= 1'b0;
      r_busy        <= 1'b0;
      r_valid       <= 1'b0;
      r_w           <= '0;
      r_j           <= '0;
      r_perm        <= '0;
      r_bestPerm    <= '0;
      r_bestPermOut <= '0;
      r_best        <= '0;
      r_minCost     <= '0;
      r_count       <= '0;
      r_matchCount  <= '0;
      for (int w = 0; w < N; w++) begin
        for (int j = 0; j < N; j++) begin
          r_table[w][j] <= '0;
        end
      end
    end else begin
      case (r_state)
        // Busy stays high through the Valid cycle, so a Start in that cycle is ignored.
        IDLE: begin
          r_w <= '0;
          r_j <= '0;
          if (r_valid) begin
            r_valid <= 1'b0;
            r_busy  <= 1'b0;
          end else if (bus.i_start) begin
            r_mode  <= bus.i_mode;
            r_busy  <= 1'b1;
            r_state <= LOAD;
          end
        end

        LOAD: begin
          r_table[r_w][r_j] <= bus.i_cost;
          if (r_j == LAST_IDX) begin
            r_j <= '0;
            if (r_w == LAST_IDX) begin
              r_w     <= '0;
              r_perm  <= identityPerm();
              r_first <= 1'b1;
              r_state <= EVAL;
            end else begin
              r_w <= r_w + IW'(1);
            end
          end else begin
            r_j <= r_j + IW'(1);
          end
        end

        // A tie only bumps the count, so the stored assignment stays the first optimum found.
        EVAL: begin
          if (r_first || w_better) begin
            r_best     <= w_total;
            r_count    <= MCW'(1);
            r_bestPerm <= r_perm;
          end else if (w_equal && (r_count != COUNT_MAX)) begin
            r_count <= r_count + MCW'(1);
          end
          r_first <= 1'b0;
          r_perm  <= w_nextPerm;
          if (w_last) begin
            r_state <= DONE;
          end
        end

        DONE: begin
          r_matchCount  <= r_count;
          r_minCost     <= r_best;
          r_bestPermOut <= r_bestPerm;
          r_valid       <= 1'b1;
          r_state       <= IDLE;
        end

        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.o_w          = r_w;
  assign bus.o_j          = r_j;
  assign bus.o_busy       = r_busy;
  assign bus.o_valid      = r_valid;
  assign bus.o_matchCount = r_matchCount;
  assign bus.o_minCost    = r_minCost;
  assign bus.o_bestPerm   = r_bestPermOut;

endmodule

// File: tb/tb_jam_gen.sv
// Self-checking bench for jam_gen. It runs table vectors and random tables on an N=3 solver
// against a brute-force model, and runs two N=8 solvers in parallel for full-size results.
module tb_jam_gen;
  import jam_pkg::*;

  typedef struct packed {
    logic              mode;
    logic [8:0][6:0]   cost;
    logic [15:0]       expCost;
    logic [15:0]       expCount;
    logic [5:0]        expPerm;
  } vec_t;

  typedef struct packed {
    logic [31:0] cost;
    logic [31:0] count;
    logic [5:0]  perm;
  } result_t;

  logic clk = 1'b0;
  logic rst3;
  logic rst8;
  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  logic [6:0] rom3 [3][3];

  jam_gen_if #(.N(3), .CW(7), .MCW(16)) n3If ();
  jam_gen_if #(.N(3), .CW(7), .MCW(2))  satIf ();
  jam_gen_if #(.N(8), .CW(7), .MCW(16)) aIf ();
  jam_gen_if #(.N(8), .CW(7), .MCW(16)) bIf ();

  jam_gen #(.N(3), .CW(7), .MCW(16)) u3   (.i_clk(clk), .i_rst(rst3), .bus(n3If));
  jam_gen #(.N(3), .CW(7), .MCW(2))  uSat (.i_clk(clk), .i_rst(rst3), .bus(satIf));
  jam_gen #(.N(8), .CW(7), .MCW(16)) u8a  (.i_clk(clk), .i_rst(rst8), .bus(aIf));
  jam_gen #(.N(8), .CW(7), .MCW(16)) u8b  (.i_clk(clk), .i_rst(rst8), .bus(bIf));

  assign n3If.i_cost  = rom3[n3If.o_w][n3If.o_j];
  assign satIf.i_cost = rom3[satIf.o_w][satIf.o_j];
  assign satIf.i_start = n3If.i_start;
  assign satIf.i_mode  = n3If.i_mode;
  assign aIf.i_cost = 7'd127;
  assign bIf.i_cost = (bIf.o_w == bIf.o_j) ? 7'd0 : 7'd10;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  // Brute force over all 27 index tuples in lexicographic order, keeping only the permutations.
  function automatic result_t refModel(input logic [8:0][6:0] cost, input logic mode);
    result_t r;
    bit have;
    have = 0;
    r = '0;
    for (int idx = 0; idx < 27; idx++) begin
      int a0, a1, a2, s;
      a0 = idx / 9;
      a1 = (idx / 3) % 3;
      a2 = idx % 3;
      if (a0 == a1 || a0 == a2 || a1 == a2) continue;
      s = int'(cost[a0]) + int'(cost[3 + a1]) + int'(cost[6 + a2]);
      if (!have || (mode ? (s > int'(r.cost)) : (s < int'(r.cost)))) begin
        have = 1;
        r.cost = s;
        r.count = 1;
        r.perm = {2'(a2), 2'(a1), 2'(a0)};
      end else if (s == int'(r.cost)) begin
        r.count = r.count + 1;
      end
    end
    return r;
  endfunction

  task automatic applyStimulus(input logic [8:0][6:0] cost, input logic mode, input int pokeAt,
                               input int abortAt, output int lat, output bit busyOk, output bit addrOk);
    busyOk = 1;
    addrOk = 1;
    @(negedge clk);
    for (int w = 0; w < 3; w++)
      for (int j = 0; j < 3; j++)
        rom3[w][j] = cost[w*3 + j];
    n3If.i_start = 1'b1;
    n3If.i_mode  = mode;
    @(posedge clk);
    #1;
    n3If.i_start = 1'b0;
    n3If.i_mode  = ~mode;
    lat = 0;
    do begin
      @(posedge clk);
      #1;
      lat++;
      if (lat == 1 && !(n3If.o_w == 2'd0 && n3If.o_j == 2'd1)) addrOk = 0;
      if (lat == 3 && !(n3If.o_w == 2'd1 && n3If.o_j == 2'd0)) addrOk = 0;
      if (!n3If.o_busy) busyOk = 0;
      if (lat == 9) begin
        for (int w = 0; w < 3; w++)
          for (int j = 0; j < 3; j++)
            rom3[w][j] = 7'($urandom_range(0, 127));
      end
      if (lat == pokeAt) begin
        n3If.i_start = 1'b1;
        n3If.i_mode  = mode;
      end
      if (lat == pokeAt + 1) n3If.i_start = 1'b0;
    end while (!n3If.o_valid && lat < 100 && lat != abortAt);
  endtask

  task automatic checkRun(input string tag, input int lat, input bit busyOk, input bit addrOk,
                          input int expCost, input int expCount, input logic [5:0] expPerm);
    checkOutput({tag, ".latency"}, lat, 16);
    checkOutput({tag, ".busyHeld"}, 32'(busyOk), 1);
    checkOutput({tag, ".romAddr"}, 32'(addrOk), 1);
    checkOutput({tag, ".minCost"}, 32'(n3If.o_minCost), expCost);
    checkOutput({tag, ".matchCount"}, 32'(n3If.o_matchCount), expCount);
    checkOutput({tag, ".bestPerm"}, 32'(n3If.o_bestPerm), 32'(expPerm));
    checkOutput({tag, ".satCount"}, 32'(satIf.o_matchCount), (expCount > 3) ? 3 : expCount);
    @(posedge clk);
    #1;
    checkOutput({tag, ".validPulse"}, 32'(n3If.o_valid), 0);
    checkOutput({tag, ".busyDrop"}, 32'(n3If.o_busy), 0);
  endtask

  initial begin
    vec_t vecs[6];
    logic [8:0][6:0] prod, flat5, diag;
    logic [23:0] id8;
    int lat;
    bit busyOk, addrOk;

    rst3 = 1'b1;
    rst8 = 1'b1;
    n3If.i_start = 1'b0;
    n3If.i_mode = 1'b0;
    aIf.i_start = 1'b0;
    aIf.i_mode = 1'b0;
    bIf.i_start = 1'b0;
    bIf.i_mode = 1'b0;
    for (int w = 0; w < 3; w++)
      for (int j = 0; j < 3; j++)
        rom3[w][j] = '0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset.n3.w", 32'(n3If.o_w), 0);
    checkOutput("reset.n3.j", 32'(n3If.o_j), 0);
    checkOutput("reset.n3.busy", 32'(n3If.o_busy), 0);
    checkOutput("reset.n3.valid", 32'(n3If.o_valid), 0);
    checkOutput("reset.n8.matchCount", 32'(aIf.o_matchCount), 0);
    checkOutput("reset.n8.minCost", 32'(aIf.o_minCost), 0);
    checkOutput("reset.n8.bestPerm", 32'(aIf.o_bestPerm), 0);
    @(negedge clk);
    rst3 = 1'b0;
    rst8 = 1'b0;

    for (int w = 0; w < 3; w++)
      for (int j = 0; j < 3; j++) begin
        prod[w*3 + j]  = 7'((w + 1) * (j + 1));
        flat5[w*3 + j] = 7'd5;
        diag[w*3 + j]  = (w == j) ? 7'd0 : 7'd10;
      end
    vecs[0] = '{mode: 1'b0, cost: prod,  expCost: 16'd10, expCount: 16'd1, expPerm: 6'b00_01_10};
    vecs[1] = '{mode: 1'b1, cost: prod,  expCost: 16'd14, expCount: 16'd1, expPerm: 6'b10_01_00};
    vecs[2] = '{mode: 1'b0, cost: flat5, expCost: 16'd15, expCount: 16'd6, expPerm: 6'b10_01_00};
    vecs[3] = '{mode: 1'b1, cost: flat5, expCost: 16'd15, expCount: 16'd6, expPerm: 6'b10_01_00};
    vecs[4] = '{mode: 1'b0, cost: diag,  expCost: 16'd0,  expCount: 16'd1, expPerm: 6'b10_01_00};
    vecs[5] = '{mode: 1'b1, cost: diag,  expCost: 16'd30, expCount: 16'd2, expPerm: 6'b00_10_01};
    for (int w = 0; w < 8; w++) id8[w*3 +: 3] = 3'(w);

    fork
      begin
        int lat8;
        @(negedge clk);
        aIf.i_start = 1'b1;
        bIf.i_start = 1'b1;
        @(posedge clk);
        #1;
        aIf.i_start = 1'b0;
        bIf.i_start = 1'b0;
        lat8 = 0;
        do begin
          @(posedge clk);
          #1;
          lat8++;
        end while (!aIf.o_valid && lat8 < 41000);
        checkOutput("n8.latency", lat8, 40385);
        checkOutput("n8.all127.minCost", 32'(aIf.o_minCost), 1016);
        checkOutput("n8.all127.matchCount", 32'(aIf.o_matchCount), 40320);
        checkOutput("n8.all127.bestPerm", 32'(aIf.o_bestPerm), 32'(id8));
        checkOutput("n8.diag.valid", 32'(bIf.o_valid), 1);
        checkOutput("n8.diag.minCost", 32'(bIf.o_minCost), 0);
        checkOutput("n8.diag.matchCount", 32'(bIf.o_matchCount), 1);
        checkOutput("n8.diag.bestPerm", 32'(bIf.o_bestPerm), 32'(id8));
      end
      begin
        for (int v = 0; v < 6; v++) begin
          applyStimulus(vecs[v].cost, vecs[v].mode, (v == 2) ? 5 : -10, -10, lat, busyOk, addrOk);
          checkRun($sformatf("vec%0d", v), lat, busyOk, addrOk, int'(vecs[v].expCost),
                   int'(vecs[v].expCount), vecs[v].expPerm);
        end

        // Abort in the middle of EVAL, then confirm that nothing is published and that the next run is clean.
        applyStimulus(vecs[5].cost, 1'b1, -10, 12, lat, busyOk, addrOk);
        rst3 = 1'b1;
        @(posedge clk);
        #1;
        rst3 = 1'b0;
        checkOutput("midReset.busy", 32'(n3If.o_busy), 0);
        checkOutput("midReset.minCost", 32'(n3If.o_minCost), 0);
        checkOutput("midReset.matchCount", 32'(n3If.o_matchCount), 0);
        checkOutput("midReset.bestPerm", 32'(n3If.o_bestPerm), 0);
        checkOutput("midReset.w", 32'(n3If.o_w), 0);
        begin
          int seen;
          seen = 0;
          repeat (30) begin
            @(posedge clk);
            #1;
            if (n3If.o_valid || satIf.o_valid) seen++;
          end
          checkOutput("midReset.noValid", seen, 0);
        end
        applyStimulus(vecs[0].cost, 1'b0, -10, -10, lat, busyOk, addrOk);
        checkRun("afterReset", lat, busyOk, addrOk, 10, 1, 6'b00_01_10);

        for (int r = 0; r < 10; r++) begin
          logic [8:0][6:0] rc;
          logic rm;
          result_t exp;
          for (int k = 0; k < 9; k++) rc[k] = 7'($urandom_range(0, 3));
          rm = 1'($urandom_range(0, 1));
          exp = refModel(rc, rm);
          applyStimulus(rc, rm, (r % 3 == 0) ? 7 : -10, -10, lat, busyOk, addrOk);
          checkRun($sformatf("rand%0d", r), lat, busyOk, addrOk, int'(exp.cost), int'(exp.count), exp.perm);
        end
      end
    join

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
